// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: operand-entry bus between the switch/button panel and the loader.
interface alu_operand_loader_if #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 4
);
    logic [WIDTH-1:0]     data_in;
    logic                 btn_enter;
    logic                 btn_clear;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [SEL_WIDTH-1:0] sel;
    logic                 operands_valid;
    logic [1:0]           state;

    modport master (
        output data_in, btn_enter, btn_clear,
        input  a, b, sel, operands_valid, state
    );
    modport slave (
        input  data_in, btn_enter, btn_clear,
        output a, b, sel, operands_valid, state
    );
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounces ENTER/CLEAR and steps a, b, sel into registered ALU operands.
module alu_operand_loader #(
    parameter int WIDTH        = 4,
    parameter int SEL_WIDTH    = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input logic clk,
    input logic rst,
    alu_operand_loader_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    if (SEL_WIDTH > WIDTH) begin : g_bad_sel
        $error("SEL_WIDTH must not exceed WIDTH");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYC must be at least 1");
    end

    typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, DONE} state_t;

    logic [1:0] raw;
    logic [1:0] pulses;
    state_t     st;

    assign raw = {bus.btn_clear, bus.btn_enter};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]    sync;
        logic          level;
        logic [CW-1:0] cnt;
        logic          p;
        // Pulse is registered on the same edge the debounced level rises.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync  <= '0;
                level <= 1'b0;
                cnt   <= '0;
                p     <= 1'b0;
            end else begin
                sync <= {sync[0], raw[i]};
                p    <= 1'b0;
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt   <= '0;
                    level <= sync[1];
                    p     <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign pulses[i] = p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st                 <= LOAD_A;
            bus.a              <= '0;
            bus.b              <= '0;
            bus.sel            <= '0;
            bus.operands_valid <= 1'b0;
        end else begin
            bus.operands_valid <= 1'b0;
            if (pulses[1]) begin
                st      <= LOAD_A;
                bus.a   <= '0;
                bus.b   <= '0;
                bus.sel <= '0;
            end else if (pulses[0]) begin
                case (st)
                    LOAD_A: begin
                        bus.a <= bus.data_in;
                        st    <= LOAD_B;
                    end
                    LOAD_B: begin
                        bus.b <= bus.data_in;
                        st    <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        bus.sel            <= bus.data_in[SEL_WIDTH-1:0];
                        bus.operands_valid <= 1'b1;
                        st                 <= DONE;
                    end
                    DONE: st <= LOAD_A;
                endcase
            end
        end
    end

    assign bus.state = st;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed and random checks of the operand loader against a window-based model.
module tb_alu_operand_loader;
    localparam int W  = 4;
    localparam int SW = 3;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_valid = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_operand_loader_if #(.WIDTH(W), .SEL_WIDTH(SW)) bus ();
    alu_operand_loader #(.WIDTH(W), .SEL_WIDTH(SW), .DEBOUNCE_CYC(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a level flips once the last D synchronized samples all disagree with it.
    logic [W-1:0] m_reg [3] = '{default: '0};
    int           m_st = 0;
    bit           m_valid = 0;
    bit           m_lvl [2] = '{0, 0};
    bit           m_p [2] = '{0, 0};
    bit           hist [2][D+1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg = '{default: '0};
            m_st = 0;
            m_valid = 0;
            m_lvl = '{0, 0};
            m_p = '{0, 0};
            hist = '{default: 0};
        end else begin
            m_valid = 0;
            if (m_p[1]) begin
                m_st = 0;
                m_reg = '{default: '0};
            end else if (m_p[0]) begin
                if (m_st < 3) m_reg[m_st] = (m_st == 2) ? (bus.data_in & W'((1 << SW) - 1)) : bus.data_in;
                m_valid = (m_st == 2);
                m_st = (m_st + 1) % 4;
            end
            for (int bi = 0; bi < 2; bi++) begin
                bit all_diff;
                all_diff = 1;
                for (int k = 1; k <= D; k++) if (hist[bi][k] == m_lvl[bi]) all_diff = 0;
                m_p[bi] = all_diff && !m_lvl[bi];
                if (all_diff) m_lvl[bi] = !m_lvl[bi];
                for (int k = D; k >= 1; k--) hist[bi][k] = hist[bi][k-1];
                hist[bi][0] = (bi == 1) ? bus.btn_clear : bus.btn_enter;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.operands_valid) n_valid++;
        if (chk_en && !rst) begin
            check("m_a", bus.a, m_reg[0]);
            check("m_b", bus.b, m_reg[1]);
            check("m_sel", bus.sel, m_reg[2]);
            check("m_state", bus.state, m_st);
            check("m_valid", bus.operands_valid, m_valid);
        end
    end

    task automatic press(input bit en, input bit cl, input logic [W-1:0] d, input int hold);
        @(negedge clk);
        bus.data_in = d;
        bus.btn_enter = en;
        bus.btn_clear = cl;
        repeat (hold) @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    initial begin
        int cyc;
        bus.data_in = W'($urandom);
        bus.btn_enter = 1'($urandom);
        bus.btn_clear = 1'($urandom);
        repeat (3) @(negedge clk);
        check("rst_a", bus.a, 0);
        check("rst_state", bus.state, 0);
        check("rst_valid", bus.operands_valid, 0);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_state", bus.state, 0);
        check("post_rst_sel", bus.sel, 0);

        n_valid = 0;
        press(1, 0, 4'd3, 8);
        press(1, 0, 4'd5, 8);
        press(1, 0, 4'd4, 8);
        check("load_a", bus.a, 3);
        check("load_b", bus.b, 5);
        check("load_sel", bus.sel, 4);
        check("load_state", bus.state, 3);
        check("strobe_count", n_valid, 1);

        press(1, 0, 4'd7, 8);
        check("wrap_state", bus.state, 0);
        check("wrap_a", bus.a, 3);
        check("wrap_sel", bus.sel, 4);
        press(1, 0, 4'd9, 8);
        check("wrap_a9", bus.a, 9);
        check("wrap_b5", bus.b, 5);

        for (int len = 1; len <= 3; len++) press(1, 0, 4'd2, len);
        check("glitch_state", bus.state, 1);
        press(1, 0, 4'd11, 200);
        check("held_state", bus.state, 2);
        check("held_b", bus.b, 11);
        @(negedge clk);
        bus.data_in = 4'hE;
        for (int k = 0; k < 4; k++) begin
            bus.btn_enter = k[0];
            @(negedge clk);
        end
        press(1, 0, 4'hE, 10);
        check("bounce_state", bus.state, 3);
        check("bounce_sel_masked", bus.sel, 6);

        press(1, 0, 4'd0, 8);
        press(1, 0, 4'd3, 8);
        press(1, 0, 4'd5, 8);
        check("pre_clr_state", bus.state, 2);
        n_valid = 0;
        press(0, 1, 4'd8, 8);
        check("clr_state", bus.state, 0);
        check("clr_a", bus.a, 0);
        check("clr_b", bus.b, 0);
        check("clr_strobe", n_valid, 0);
        press(1, 0, 4'd7, 8);
        press(1, 1, 4'd6, 8);
        check("both_state", bus.state, 0);
        check("both_a", bus.a, 0);

        press(1, 0, 4'd6, 8);
        check("pre_rst_a", bus.a, 6);
        @(negedge clk);
        bus.data_in = 4'hC;
        bus.btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_a", bus.a, 0);
        check("arst_state", bus.state, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (bus.state != 2'd1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("arst_latency_ok", 32'(cyc >= 6 && cyc <= 7), 1);
        check("arst_a_load", bus.a, 4'hC);
        bus.btn_enter = 1'b0;
        repeat (D + 6) @(negedge clk);

        for (int it = 0; it < 200; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            bus.data_in = W'($urandom);
            bus.btn_enter = 1'($urandom);
            bus.btn_clear = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (D + 6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
